// File: rtl/eda_regmax_pkg.sv
// Shared types and constants for the regional-maximum sequencer.
// Slot indices follow the bit order of nbr_addr / push_positions / win_equal.
package eda_regmax_pkg;

  localparam int NBR_CNT = 8;

  localparam int UPLEFT    = 7;
  localparam int UP        = 6;
  localparam int UPRIGHT   = 5;
  localparam int LEFT      = 4;
  localparam int RIGHT     = 3;
  localparam int DOWNLEFT  = 2;
  localparam int DOWN      = 1;
  localparam int DOWNRIGHT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEED,
    S_FETCH,
    S_EXPAND,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/eda_regmax_ctrl_if.sv
// Bus between the sequencer and its iterated memory, window unit and result sink.
interface eda_regmax_ctrl_if
  import eda_regmax_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);
    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          mem_clear;
    logic                          new_pixel;
    logic [ADDR_WIDTH-1:0]         center_addr;
    logic [NBR_CNT*ADDR_WIDTH-1:0] nbr_addr;
    logic [NBR_CNT-1:0]            push_positions;
    logic                          center_visited;
    logic [NBR_CNT-1:0]            iterated_idx;
    logic                          win_req;
    logic                          win_valid;
    logic [NBR_CNT-1:0]            win_equal;
    logic                          win_greater;
    logic                          res_we;
    logic [ADDR_WIDTH-1:0]         res_addr;
    logic                          res_data;

    modport master (
        input  start, center_visited, iterated_idx, win_valid, win_equal, win_greater,
        output busy, done, mem_clear, new_pixel, center_addr, nbr_addr, push_positions,
               win_req, res_we, res_addr, res_data
    );

    modport slave (
        output start, center_visited, iterated_idx, win_valid, win_equal, win_greater,
        input  busy, done, mem_clear, new_pixel, center_addr, nbr_addr, push_positions,
               win_req, res_we, res_addr, res_data
    );
endinterface

// File: rtl/eda_regmax_ctrl_nbr_gen.sv
// Combinational 8-neighbour address generator with in-image valid mask.
// Out-of-image slots carry wrapped addresses; only nbr_valid is meaningful there.
module eda_nbr_addr_gen
  import eda_regmax_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]              center_addr,
    output logic [NBR_CNT-1:0][ADDR_WIDTH-1:0] nbr_addr,
    output logic [NBR_CNT-1:0]                 nbr_valid
);
    logic [I_WIDTH-1:0] ci, iu, id;
    logic [J_WIDTH-1:0] cj, jl, jr;
    logic               at_top, at_bot, at_lft, at_rgt;

    assign {ci, cj} = center_addr;
    assign iu = ci - 1'b1;
    assign id = ci + 1'b1;
    assign jl = cj - 1'b1;
    assign jr = cj + 1'b1;

    assign at_top = (ci == '0);
    assign at_bot = (ci == I_WIDTH'(M - 1));
    assign at_lft = (cj == '0);
    assign at_rgt = (cj == J_WIDTH'(N - 1));

    assign nbr_addr[UPLEFT]    = {iu, jl};
    assign nbr_addr[UP]        = {iu, cj};
    assign nbr_addr[UPRIGHT]   = {iu, jr};
    assign nbr_addr[LEFT]      = {ci, jl};
    assign nbr_addr[RIGHT]     = {ci, jr};
    assign nbr_addr[DOWNLEFT]  = {id, jl};
    assign nbr_addr[DOWN]      = {id, cj};
    assign nbr_addr[DOWNRIGHT] = {id, jr};

    assign nbr_valid[UPLEFT]    = !at_top && !at_lft;
    assign nbr_valid[UP]        = !at_top;
    assign nbr_valid[UPRIGHT]   = !at_top && !at_rgt;
    assign nbr_valid[LEFT]      = !at_lft;
    assign nbr_valid[RIGHT]     = !at_rgt;
    assign nbr_valid[DOWNLEFT]  = !at_bot && !at_lft;
    assign nbr_valid[DOWN]      = !at_bot;
    assign nbr_valid[DOWNRIGHT] = !at_bot && !at_rgt;
endmodule

// File: rtl/eda_regmax_ctrl.sv
// Regional-maximum sequencer: raster scan, BFS flood fill of each unvisited plateau,
// then replay of the BFS queue to write one result bit per plateau pixel.
module eda_regmax_ctrl
  import eda_regmax_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    eda_regmax_ctrl_if.master bus
);
    localparam int PIX = M * N;
    localparam int CW  = ADDR_WIDTH + 1;   // head/tail must reach PIX

    state_e                              state, state_nxt;
    logic [ADDR_WIDTH-1:0]               queue [PIX];
    logic [CW-1:0]                       head, tail, tail_nxt;
    logic [ADDR_WIDTH-1:0]               idx, scan, cur, center;
    logic                                is_max;
    logic [NBR_CNT-1:0]                  mask, mask_rest, sel_oh;
    logic [2:0]                          sel;
    logic [NBR_CNT-1:0][ADDR_WIDTH-1:0]  nbr_addr;
    logic [NBR_CNT-1:0]                  nbr_valid;
    logic                                last_pix, q_we;
    logic [ADDR_WIDTH-1:0]               q_waddr, q_wdata;

    eda_nbr_addr_gen #(
        .M(M), .N(N), .I_WIDTH(I_WIDTH), .J_WIDTH(J_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_nbr (
        .center_addr(center),
        .nbr_addr   (nbr_addr),
        .nbr_valid  (nbr_valid)
    );

    assign bus.center_addr = center;
    assign bus.nbr_addr    = nbr_addr;
    assign bus.busy        = (state != S_IDLE);

    assign last_pix  = (scan == ADDR_WIDTH'(PIX - 1));
    assign sel_oh    = mask & (~mask + NBR_CNT'(1));
    assign mask_rest = mask & ~sel_oh;
    assign tail_nxt  = tail + {{ADDR_WIDTH{1'b0}}, |mask};

    always_comb begin
        sel = '0;
        for (int k = NBR_CNT - 1; k >= 0; k--)
            if (mask[k]) sel = 3'(k);
    end

    always_comb begin
        state_nxt          = state;
        center             = '0;
        bus.done           = 1'b0;
        bus.mem_clear      = 1'b0;
        bus.new_pixel      = 1'b0;
        bus.push_positions = '0;
        bus.win_req        = 1'b0;
        bus.res_we         = 1'b0;
        bus.res_addr       = '0;
        bus.res_data       = 1'b0;
        q_we               = 1'b0;
        q_waddr            = '0;
        q_wdata            = '0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                bus.mem_clear = 1'b1;
                state_nxt     = S_SEED;
            end
            S_SEED: begin
                center = scan;
                if (bus.center_visited) begin
                    if (last_pix) state_nxt = S_DONE;
                end else begin
                    bus.new_pixel = 1'b1;
                    q_we          = 1'b1;
                    q_wdata       = scan;
                    state_nxt     = S_FETCH;
                end
            end
            S_FETCH: begin
                center      = queue[head[ADDR_WIDTH-1:0]];
                bus.win_req = 1'b1;
                if (bus.win_valid) state_nxt = S_EXPAND;
            end
            S_EXPAND: begin
                center = cur;
                if (mask != '0) begin
                    bus.push_positions = sel_oh;
                    q_we               = 1'b1;
                    q_waddr            = tail[ADDR_WIDTH-1:0];
                    q_wdata            = nbr_addr[sel];
                end
                // the final push and the exit decision share a cycle
                if (mask_rest == '0) state_nxt = (head < tail_nxt) ? S_FETCH : S_WRITE;
            end
            S_WRITE: begin
                center       = cur;
                bus.res_we   = 1'b1;
                bus.res_addr = queue[idx];
                bus.res_data = is_max;
                if ({1'b0, idx} == tail - CW'(1)) state_nxt = last_pix ? S_DONE : S_SEED;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (q_we) queue[q_waddr] <= q_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            scan   <= '0;
            head   <= '0;
            tail   <= '0;
            idx    <= '0;
            cur    <= '0;
            is_max <= 1'b0;
            mask   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: scan <= '0;
                S_SEED: begin
                    if (bus.center_visited) begin
                        if (!last_pix) scan <= scan + 1'b1;
                    end else begin
                        head   <= '0;
                        tail   <= CW'(1);
                        is_max <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.win_valid) begin
                        head <= head + 1'b1;
                        cur  <= center;
                        mask <= bus.win_equal & ~bus.iterated_idx & nbr_valid;
                        if (bus.win_greater) is_max <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    tail <= tail_nxt;
                    mask <= mask_rest;
                    idx  <= '0;
                end
                S_WRITE: begin
                    idx <= idx + 1'b1;
                    if ({1'b0, idx} == tail - CW'(1) && !last_pix) scan <= scan + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eda_regmax_ctrl.sv
// Randomized bench for eda_regmax_ctrl on a 4x4 image with behavioural
// iterated memory, window unit and a label-propagation regional-max model.
module tb_eda_regmax_ctrl;
    localparam int M = 4, N = 4, AW = 4, P = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eda_regmax_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
    eda_regmax_ctrl #(.M(M), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tot = 0, n_bad = 0;
    int img [P];
    bit visited [P];
    bit exp_res [P];
    int n_plat;
    int win_delay = 0, wait_cnt = 0;
    bit force_ff = 1'b0;
    int push_log [$];
    int push_cyc [$];
    int first_len, unstable, early_push;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // slots 7..0: upleft, up, upright, left, right, downleft, down, downright
    function automatic int nbr(input int p, input int k);
        int i, j, di, dj;
        i = p / N; j = p % N;
        case (k)
            7: begin di = -1; dj = -1; end
            6: begin di = -1; dj =  0; end
            5: begin di = -1; dj =  1; end
            4: begin di =  0; dj = -1; end
            3: begin di =  0; dj =  1; end
            2: begin di =  1; dj = -1; end
            1: begin di =  1; dj =  0; end
            default: begin di = 1; dj = 1; end
        endcase
        i += di; j += dj;
        if (i < 0 || i >= M || j < 0 || j >= N) return -1;
        return i * N + j;
    endfunction

    function automatic int outs();
        return int'({bus.busy, bus.done, bus.mem_clear, bus.new_pixel, bus.win_req,
                     bus.res_we, bus.res_data, bus.push_positions, bus.center_addr});
    endfunction

    always_comb begin
        int c, q;
        c = int'(bus.center_addr);
        bus.center_visited = visited[c];
        bus.iterated_idx   = '0;
        bus.win_equal      = '0;
        bus.win_greater    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            q = nbr(c, k);
            if (q >= 0) begin
                bus.iterated_idx[k] = visited[q];
                bus.win_equal[k]    = (img[q] == img[c]);
                if (img[q] > img[c]) bus.win_greater = 1'b1;
            end
        end
        if (force_ff) bus.win_equal = 8'hFF;
        bus.win_valid = bus.win_req && (wait_cnt >= win_delay);
    end

    always @(posedge clk) begin
        if (bus.win_req && !bus.win_valid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.mem_clear) for (int k = 0; k < P; k++) visited[k] <= 1'b0;
        if (bus.new_pixel) visited[bus.center_addr] <= 1'b1;
        for (int k = 0; k < 8; k++)
            if (bus.push_positions[k] && nbr(int'(bus.center_addr), k) >= 0)
                visited[nbr(int'(bus.center_addr), k)] <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // regional maxima by label propagation over 8-connected equal plateaus
    task automatic ref_model();
        int lab [P];
        bit hg [P];
        int q;
        for (int p = 0; p < P; p++) begin lab[p] = p; hg[p] = 1'b0; end
        repeat (P) for (int p = 0; p < P; p++) for (int k = 0; k < 8; k++) begin
            q = nbr(p, k);
            if (q >= 0 && img[q] == img[p] && lab[q] < lab[p]) lab[p] = lab[q];
        end
        for (int p = 0; p < P; p++) for (int k = 0; k < 8; k++) begin
            q = nbr(p, k);
            if (q >= 0 && img[q] > img[p]) hg[lab[p]] = 1'b1;
        end
        n_plat = 0;
        for (int p = 0; p < P; p++) if (lab[p] == p) n_plat++;
        for (int p = 0; p < P; p++) exp_res[p] = !hg[lab[p]];
    endtask

    task automatic run_frame(input string nm, input int restart_at, output int ones);
        int wr_cnt [P];
        bit got [P];
        int cyc, n_np, n_done, n_clr, excl, pbad, rbad, run, q, c;
        bit fin, in_req, seen_valid;
        logic [AW-1:0] req_c;
        ref_model();
        for (int p = 0; p < P; p++) begin wr_cnt[p] = 0; got[p] = 1'b0; end
        n_np = 0; n_done = 0; n_clr = 0; excl = 0; pbad = 0; run = 0;
        fin = 1'b0; in_req = 1'b0; seen_valid = 1'b0; req_c = '0;
        first_len = -1; unstable = 0; early_push = 0;
        push_log.delete(); push_cyc.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            c = int'(bus.center_addr);
            if (bus.mem_clear) n_clr++;
            if (bus.done) begin n_done++; fin = 1'b1; end
            if (int'(bus.new_pixel) + int'(bus.res_we) + $countones(bus.push_positions) > 1) excl++;
            if (bus.new_pixel) begin
                n_np++;
                if (visited[c]) pbad++;
            end
            if (bus.push_positions != '0) begin
                if (!seen_valid) early_push++;
                for (int k = 0; k < 8; k++) if (bus.push_positions[k]) begin
                    q = nbr(c, k);
                    if (q < 0) pbad++;
                    else if (visited[q]) pbad++;
                end
                push_log.push_back(int'(bus.push_positions));
                push_cyc.push_back(cyc);
            end
            if (bus.res_we) begin
                wr_cnt[bus.res_addr]++;
                got[bus.res_addr] = bus.res_data;
            end
            if (bus.win_req) begin
                if (in_req && bus.center_addr != req_c) unstable++;
                if (!in_req) begin in_req = 1'b1; req_c = bus.center_addr; run = 0; end
                run++;
                if (bus.win_valid) begin
                    in_req = 1'b0; seen_valid = 1'b1;
                    if (first_len < 0) first_len = run;
                end
            end
            bus.start = (cyc == restart_at);
            if (!fin) begin tick(); cyc++; end
        end
        bus.start = 1'b0;
        chk({nm, ":finished"}, int'(fin), 1);
        chk({nm, ":done_cnt"}, n_done, 1);
        chk({nm, ":clr_cnt"}, n_clr, 1);
        chk({nm, ":plateaus"}, n_np, n_plat);
        chk({nm, ":exclusive"}, excl, 0);
        chk({nm, ":push_tgt"}, pbad, 0);
        rbad = 0; ones = 0;
        for (int p = 0; p < P; p++) begin
            if (wr_cnt[p] != 1 || got[p] != exp_res[p]) rbad++;
            if (got[p]) ones++;
        end
        chk({nm, ":results"}, rbad, 0);
        tick();
        chk({nm, ":idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int ones, quiet;
        bus.start = 1'b0;
        reset = 1'b1;
        for (int p = 0; p < P; p++) img[p] = 5;
        repeat (3) tick();
        chk("rst:outs", outs(), 0);
        reset = 1'b0;
        tick();
        chk("rst:outs_rel", outs(), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start:mem_clear", int'(bus.mem_clear), 1);
        chk("start:busy", int'(bus.busy), 1);
        tick();
        chk("start:clear_1cyc", int'(bus.mem_clear), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("start:abort_outs", outs(), 0);

        // flat image: one plateau, every pixel a maximum
        run_frame("flat", -1, ones);
        chk("flat:ones", ones, 16);

        // single peak at (1,1)
        for (int p = 0; p < P; p++) img[p] = 1;
        img[5] = 9;
        run_frame("peak", -1, ones);
        chk("peak:ones", ones, 1);
        chk("peak:res5", int'(exp_res[5]), 1);

        // slow window on a random image
        for (int p = 0; p < P; p++) img[p] = $urandom_range(0, 2);
        win_delay = 5;
        run_frame("delay", -1, ones);
        chk("delay:req_len", first_len, 6);
        chk("delay:stable", unstable, 0);
        chk("delay:early_push", early_push, 0);
        win_delay = 0;

        // corner seed with every neighbour reported equal
        for (int p = 0; p < P; p++) img[p] = 3;
        force_ff = 1'b1;
        run_frame("corner", -1, ones);
        force_ff = 1'b0;
        chk("corner:npush", (push_log.size() >= 3) ? 1 : 0, 1);
        if (push_log.size() >= 3) begin
            chk("corner:push0", push_log[0], 8'h01);
            chk("corner:push1", push_log[1], 8'h02);
            chk("corner:push2", push_log[2], 8'h08);
            chk("corner:consec", push_cyc[2] - push_cyc[0], 2);
        end

        // reset during EXPAND
        for (int p = 0; p < P; p++) img[p] = $urandom_range(0, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        quiet = 0;
        while (bus.push_positions == '0 && quiet < 500) begin tick(); quiet++; end
        chk("abort:in_expand", int'(bus.push_positions != '0), 1);
        reset = 1'b1;
        tick();
        chk("abort:outs", outs(), 0);
        reset = 1'b0;
        quiet = 0;
        repeat (20) begin
            tick();
            if (bus.done || bus.mem_clear || bus.busy) quiet++;
        end
        chk("abort:quiet", quiet, 0);

        // random frames with a start pulse issued mid-frame
        for (int t = 0; t < 5; t++) begin
            for (int p = 0; p < P; p++) img[p] = (t < 3) ? $urandom_range(0, 2) : $urandom_range(0, 7);
            win_delay = $urandom_range(0, 3);
            run_frame($sformatf("rand%0d", t), 12, ones);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
